// File: rtl/shift_normalizer_seq.sv
// rtl/shift_normalizer_seq.sv - sequential leading/trailing-zero normalizer
// Shifts the operand one bit per clock toward the chosen edge and reports the distance.
module shift_normalizer_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  LnR,
  output logic [DATA_WIDTH-1:0] Y,
  output logic [CNT_WIDTH-1:0]  CNT,
  output logic                  ZERO,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic                    dir_q, dir_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    zero_q, zero_d;
  logic                    target_bit;

  // dir=1 walks toward the MSB (leading zeros), dir=0 toward the LSB (trailing zeros)
  assign target_bit = dir_q ? work_q[DATA_WIDTH-1] : work_q[0];

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          work_d  = D;
          dir_d   = LnR;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (work_q == '0) begin
          cnt_d   = CNT_WIDTH'(DATA_WIDTH);
          zero_d  = 1'b1;
          state_d = DONE_S;
        end else if (target_bit) begin
          state_d = DONE_S;
        end else begin
          work_d = dir_q ? (work_q << 1) : (work_q >> 1);
          cnt_d  = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE_S: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      work_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // Status decoded straight from the state register so reset clears it without a clock
  assign Y    = work_q;
  assign CNT  = cnt_q;
  assign ZERO = zero_q;
  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == DONE_S);

endmodule

// File: tb/tb_shift_normalizer_seq.sv
// tb/tb_shift_normalizer_seq.sv - scoreboard bench for shift_normalizer_seq
module tb_shift_normalizer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] d;
  logic        lnr;
  logic [31:0] y;
  logic [5:0]  cnt;
  logic        zero;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] d;
    logic        lnr;
    logic [31:0] y;
    logic [5:0]  cnt;
    logic        zero;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];

  shift_normalizer_seq #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .CLK(clk), .RST(rst), .START(start), .D(d), .LnR(lnr),
    .Y(y), .CNT(cnt), .ZERO(zero), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t ref_model(input logic [31:0] op, input logic dir);
    exp_t e;
    int   n;
    bit   found;
    e.d = op;
    e.lnr = dir;
    e.start_cyc = 0;
    n = 0;
    found = 0;
    if (op == 32'h0) begin
      e.y = 32'h0; e.cnt = 6'd32; e.zero = 1'b1; e.lat = 1;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (!found && (dir ? op[31-i] : op[i])) begin
          n = i;
          found = 1;
        end
      end
      e.y = dir ? (op << n) : (op >> n);
      e.cnt = 6'(n);
      e.zero = 1'b0;
      e.lat = n + 1;
    end
    return e;
  endfunction

  task automatic start_op(input logic [31:0] op, input logic dir);
    exp_t e;
    @(negedge clk);
    start = 1'b1; d = op; lnr = dir;
    @(posedge clk); #1;
    start = 1'b0; d = $urandom; lnr = $urandom_range(0, 1);
    e = ref_model(op, dir);
    e.start_cyc = cyc;
    exp_q.push_back(e);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    exp_t        e;
    int          n;
    bit          seen;
    logic [31:0] back;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      if (seen) begin
        chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
        chk("y", 64'(y), 64'(e.y));
        chk("cnt", 64'(cnt), 64'(e.cnt));
        chk("zero", 64'(zero), 64'(e.zero));
        chk("busy_in_done", 64'(busy), 64'd0);
        back = e.lnr ? (y >> cnt) : (y << cnt);
        chk("inverse_shift", 64'(back), 64'(e.d));
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("y_hold", 64'(y), 64'(e.y));
        chk("cnt_hold", 64'(cnt), 64'(e.cnt));
      end else begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; d = 32'h0; lnr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    start_op(32'h0001_0000, 1'b1); wait_done();
    start_op(32'h0000_0100, 1'b0); wait_done();
    start_op(32'h8000_0000, 1'b0); wait_done();
    start_op(32'h8000_0000, 1'b1); wait_done();
    start_op(32'h0000_0000, 1'b1); wait_done();
    start_op(32'h0000_0000, 1'b0); wait_done();
    start_op(32'h0000_0001, 1'b0); wait_done();

    // START during SHIFT must be ignored
    d0 = done_cnt;
    start_op(32'h0000_0001, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; d = 32'hFFFF_FFFF; lnr = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk); #1;
    chk("single_done_pulse", 64'(done_cnt - d0), 64'd1);
    chk("busy_ignored_y", 64'(y), 64'h8000_0000);

    // asynchronous reset between edges during SHIFT
    start_op(32'h0000_0001, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_y", 64'(y), 64'd0);
    chk("async_rst_cnt", 64'(cnt), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    void'(exp_q.pop_back());
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    chk("idle_after_rst", 64'(busy), 64'd0);
    start_op(32'h00F0_0000, 1'b1); wait_done();

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] op;
      op = $urandom;
      case ($urandom_range(0, 3))
        0: op = op >> $urandom_range(0, 31);
        1: op = op << $urandom_range(0, 31);
        2: if ($urandom_range(0, 15) == 0) op = 32'h0;
        default: ;
      endcase
      start_op(op, 1'($urandom_range(0, 1)));
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
